axi4_mmio_responder: RTL and testbench

AXI4_MMIO_RESPONDER -- requirements
Module: axi4_mmio_responder

---
 rtl/axi4_mmio_responder.sv | 196 +++++++++++++++++++
 tb/tb_axi4_mmio_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mmio_responder.sv
// AXI4 slave exposing NUM_WORDS x 64-bit registers as INCR bursts with independent read/write FSMs.
// Optional MMIO_RESP_ERR_EN: out-of-window start addresses get SLVERR and never touch the array.
module axi4_mmio_responder #(
    parameter int                    ADDR_WIDTH = 30,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    NUM_WORDS  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 30'h1000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  S_AXI_MMIO_AWVALID,
    output logic                  S_AXI_MMIO_AWREADY,
    input  logic [ID_WIDTH-1:0]   S_AXI_MMIO_AWID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_MMIO_AWADDR,
    input  logic [7:0]            S_AXI_MMIO_AWLEN,
    input  logic                  S_AXI_MMIO_WVALID,
    output logic                  S_AXI_MMIO_WREADY,
    input  logic [63:0]           S_AXI_MMIO_WDATA,
    input  logic [7:0]            S_AXI_MMIO_WSTRB,
    input  logic                  S_AXI_MMIO_WLAST,
    output logic                  S_AXI_MMIO_BVALID,
    input  logic                  S_AXI_MMIO_BREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_MMIO_BID,
    output logic [1:0]            S_AXI_MMIO_BRESP,
    input  logic                  S_AXI_MMIO_ARVALID,
    output logic                  S_AXI_MMIO_ARREADY,
    input  logic [ID_WIDTH-1:0]   S_AXI_MMIO_ARID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_MMIO_ARADDR,
    input  logic [7:0]            S_AXI_MMIO_ARLEN,
    output logic                  S_AXI_MMIO_RVALID,
    input  logic                  S_AXI_MMIO_RREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_MMIO_RID,
    output logic [63:0]           S_AXI_MMIO_RDATA,
    output logic [1:0]            S_AXI_MMIO_RRESP,
    output logic                  S_AXI_MMIO_RLAST
);

    localparam int               IDX_W   = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    logic [63:0]      mem [NUM_WORDS];
    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len;
    logic [7:0]       w_cnt;
    logic             w_err;
    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;
    logic             r_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_bad, ar_bad;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic unused_bits;

    // A transfer happens on a rising edge where VALID and READY are both high; VALID never waits for READY.
    assign aw_hs  = S_AXI_MMIO_AWVALID && S_AXI_MMIO_AWREADY;
    assign w_hs   = S_AXI_MMIO_WVALID  && S_AXI_MMIO_WREADY;
    assign b_hs   = S_AXI_MMIO_BVALID  && S_AXI_MMIO_BREADY;
    assign ar_hs  = S_AXI_MMIO_ARVALID && S_AXI_MMIO_ARREADY;
    assign r_hs   = S_AXI_MMIO_RVALID  && S_AXI_MMIO_RREADY;
    assign aw_idx = S_AXI_MMIO_AWADDR[IDX_W+2:3];
    assign ar_idx = S_AXI_MMIO_ARADDR[IDX_W+2:3];
    assign unused_bits = ^{S_AXI_MMIO_WLAST, S_AXI_MMIO_AWADDR, S_AXI_MMIO_ARADDR};

`ifdef MMIO_RESP_ERR_EN
    localparam logic [ADDR_WIDTH:0] WIN_END = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(NUM_WORDS * 8);

    function automatic logic out_of_window(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < {1'b0, BASE_ADDR}) || ({1'b0, a} >= WIN_END);
    endfunction

    assign aw_bad = out_of_window(S_AXI_MMIO_AWADDR);
    assign ar_bad = out_of_window(S_AXI_MMIO_ARADDR);
`else
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
`endif

    // Write side: also owns the storage array, so reset clears it here.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state            <= W_IDLE;
            S_AXI_MMIO_AWREADY <= 1'b0;
            S_AXI_MMIO_WREADY  <= 1'b0;
            S_AXI_MMIO_BVALID  <= 1'b0;
            S_AXI_MMIO_BID     <= '0;
            S_AXI_MMIO_BRESP   <= 2'b00;
            w_idx              <= '0;
            w_len              <= 8'd0;
            w_cnt              <= 8'd0;
            w_err              <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AXI_MMIO_AWREADY <= 1'b1;
                    if (aw_hs) begin
                        S_AXI_MMIO_AWREADY <= 1'b0;
                        S_AXI_MMIO_WREADY  <= 1'b1;
                        S_AXI_MMIO_BID     <= S_AXI_MMIO_AWID;
                        w_idx              <= aw_idx;
                        w_len              <= S_AXI_MMIO_AWLEN;
                        w_cnt              <= 8'd0;
                        w_err              <= aw_bad;
                        w_state            <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (!w_err) begin
                            for (int b = 0; b < 8; b++) begin
                                if (S_AXI_MMIO_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_MMIO_WDATA[8*b +: 8];
                            end
                        end
                        w_idx <= w_idx + IDX_ONE;
                        w_cnt <= w_cnt + 8'd1;
                        // The beat count, not WLAST, closes the burst.
                        if (w_cnt == w_len) begin
                            S_AXI_MMIO_WREADY <= 1'b0;
                            S_AXI_MMIO_BVALID <= 1'b1;
                            S_AXI_MMIO_BRESP  <= w_err ? 2'b10 : 2'b00;
                            w_state           <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        S_AXI_MMIO_BVALID  <= 1'b0;
                        S_AXI_MMIO_AWREADY <= 1'b1;
                        w_state            <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read side: RDATA is a register loaded from the array, so a write landing on the same edge is not seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= R_IDLE;
            S_AXI_MMIO_ARREADY <= 1'b0;
            S_AXI_MMIO_RVALID  <= 1'b0;
            S_AXI_MMIO_RID     <= '0;
            S_AXI_MMIO_RDATA   <= 64'd0;
            S_AXI_MMIO_RRESP   <= 2'b00;
            S_AXI_MMIO_RLAST   <= 1'b0;
            r_idx              <= '0;
            r_len              <= 8'd0;
            r_cnt              <= 8'd0;
            r_err              <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_MMIO_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        S_AXI_MMIO_ARREADY <= 1'b0;
                        S_AXI_MMIO_RVALID  <= 1'b1;
                        S_AXI_MMIO_RID     <= S_AXI_MMIO_ARID;
                        S_AXI_MMIO_RDATA   <= ar_bad ? 64'd0 : mem[ar_idx];
                        S_AXI_MMIO_RRESP   <= ar_bad ? 2'b10 : 2'b00;
                        S_AXI_MMIO_RLAST   <= (S_AXI_MMIO_ARLEN == 8'd0);
                        r_idx              <= ar_idx + IDX_ONE;
                        r_len              <= S_AXI_MMIO_ARLEN;
                        r_cnt              <= 8'd0;
                        r_err              <= ar_bad;
                        r_state            <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (S_AXI_MMIO_RLAST) begin
                            S_AXI_MMIO_RVALID  <= 1'b0;
                            S_AXI_MMIO_RLAST   <= 1'b0;
                            S_AXI_MMIO_ARREADY <= 1'b1;
                            r_state            <= R_IDLE;
                        end else begin
                            S_AXI_MMIO_RDATA <= r_err ? 64'd0 : mem[r_idx];
                            S_AXI_MMIO_RLAST <= ((r_cnt + 8'd1) == r_len);
                            r_idx            <= r_idx + IDX_ONE;
                            r_cnt            <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mmio_responder.sv
// Directed bench for axi4_mmio_responder: a table of single-beat writes/reads plus hand-built
// sequences for read stalls, concurrent read/write, reset mid-burst and address aliasing/errors.
module tb_axi4_mmio_responder;

    localparam int              AW   = 30;
    localparam int              IW   = 4;
    localparam int              NW   = 16;
    localparam logic [AW-1:0]   BASE = 30'h1000_0000;
    localparam int              WAIT_LIMIT = 50;

    logic          clock = 1'b0;
    logic          reset;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen, wstrb;
    logic [63:0]   wdata, rdata;
    logic [1:0]    bresp, rresp;

    logic [63:0] model [NW];
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    axi4_mmio_responder dut (
        .clock(clock), .reset(reset),
        .S_AXI_MMIO_AWVALID(awvalid), .S_AXI_MMIO_AWREADY(awready), .S_AXI_MMIO_AWID(awid),
        .S_AXI_MMIO_AWADDR(awaddr), .S_AXI_MMIO_AWLEN(awlen),
        .S_AXI_MMIO_WVALID(wvalid), .S_AXI_MMIO_WREADY(wready), .S_AXI_MMIO_WDATA(wdata),
        .S_AXI_MMIO_WSTRB(wstrb), .S_AXI_MMIO_WLAST(wlast),
        .S_AXI_MMIO_BVALID(bvalid), .S_AXI_MMIO_BREADY(bready), .S_AXI_MMIO_BID(bid),
        .S_AXI_MMIO_BRESP(bresp),
        .S_AXI_MMIO_ARVALID(arvalid), .S_AXI_MMIO_ARREADY(arready), .S_AXI_MMIO_ARID(arid),
        .S_AXI_MMIO_ARADDR(araddr), .S_AXI_MMIO_ARLEN(arlen),
        .S_AXI_MMIO_RVALID(rvalid), .S_AXI_MMIO_RREADY(rready), .S_AXI_MMIO_RID(rid),
        .S_AXI_MMIO_RDATA(rdata), .S_AXI_MMIO_RRESP(rresp), .S_AXI_MMIO_RLAST(rlast)
    );

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All driver tasks start and end on a falling edge.
    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        int n = 0;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
        while (!awready && n < WAIT_LIMIT) begin @(negedge clock); n++; end
        check("awready_wait", 64'(n < WAIT_LIMIT), 64'd1);
        @(negedge clock);
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        int n = 0;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
        while (!arready && n < WAIT_LIMIT) begin @(negedge clock); n++; end
        check("arready_wait", 64'(n < WAIT_LIMIT), 64'd1);
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input bit last,
                          input int widx, input bit apply);
        int n = 0;
        wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
        while (!wready && n < WAIT_LIMIT) begin @(negedge clock); n++; end
        check("wready_wait", 64'(n < WAIT_LIMIT), 64'd1);
        if (apply) begin
            for (int b = 0; b < 8; b++) if (strb[b]) model[widx][8*b +: 8] = data[8*b +: 8];
        end
        @(negedge clock);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_take(input logic [IW-1:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        while (!bvalid && n < WAIT_LIMIT) begin @(negedge clock); n++; end
        check("bvalid_wait", 64'(n < WAIT_LIMIT), 64'd1);
        check("bid", 64'(bid), 64'(exp_id));
        check("bresp", 64'(bresp), 64'(exp_resp));
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        check("bvalid_drop", 64'(bvalid), 64'd0);
    endtask

    task automatic r_beat(input logic [63:0] exp_data, input logic [IW-1:0] exp_id,
                          input logic [1:0] exp_resp, input bit exp_last, input bit stall);
        int n = 0;
        while (!rvalid && n < WAIT_LIMIT) begin @(negedge clock); n++; end
        check("rvalid_wait", 64'(n < WAIT_LIMIT), 64'd1);
        if (stall) begin
            @(negedge clock);
            check("rvalid_stall", 64'(rvalid), 64'd1);
        end
        check("rdata", rdata, exp_data);
        check("rid", 64'(rid), 64'(exp_id));
        check("rresp", 64'(rresp), 64'(exp_resp));
        check("rlast", 64'(rlast), 64'(exp_last));
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
    endtask

    // RREADY held high: beats must arrive on consecutive cycles with no gaps.
    task automatic r_held(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input int start, input logic [1:0] exp_resp, input bit zero_data);
        rready = 1'b1;
        ar_send(id, addr, 8'(len));
        for (int k = 0; k <= len; k++) begin
            check("held_rvalid", 64'(rvalid), 64'd1);
            check("held_rdata", rdata, zero_data ? 64'd0 : model[(start + k) % NW]);
            check("held_rresp", 64'(rresp), 64'(exp_resp));
            check("held_rlast", 64'(rlast), 64'(k == len));
            check("held_rid", 64'(rid), 64'(id));
            @(negedge clock);
        end
        check("held_rvalid_end", 64'(rvalid), 64'd0);
        rready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; rready = 1'b0;
        for (int i = 0; i < NW; i++) model[i] = 64'd0;

        // Reset state, then readiness on the first cycle after release.
        repeat (3) @(negedge clock);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_arready", 64'(arready), 64'd1);

        vecs[0] = '{1'b1, BASE + 30'd8,  64'hDEAD_BEEF_0123_4567, 8'hFF, 64'd0};
        vecs[1] = '{1'b0, BASE + 30'd8,  64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567};
        vecs[2] = '{1'b1, BASE + 30'd16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0};
        vecs[3] = '{1'b1, BASE + 30'd16, 64'd0, 8'h0F, 64'd0};
        vecs[4] = '{1'b0, BASE + 30'd16, 64'd0, 8'h00, 64'hFFFF_FFFF_0000_0000};
        vecs[5] = '{1'b1, BASE + 30'd24, 64'h1122_3344_5566_7788, 8'hA5, 64'd0};
        vecs[6] = '{1'b0, BASE + 30'd24, 64'd0, 8'h00, 64'h1100_3300_0066_0088};
        vecs[7] = '{1'b1, BASE + 30'd120, 64'hA5A5_0000_FFFF_000F, 8'hFF, 64'd0};
        vecs[8] = '{1'b0, BASE + 30'd120, 64'd0, 8'h00, 64'hA5A5_0000_FFFF_000F};
        vecs[9] = '{1'b0, BASE, 64'd0, 8'h00, 64'd0};

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                aw_send(4'(i), vecs[i].addr, 8'd0);
                w_beat(vecs[i].data, vecs[i].strb, 1'b1, int'(vecs[i].addr[6:3]), 1'b1);
                b_take(4'(i), 2'b00);
            end else begin
                ar_send(4'(i), vecs[i].addr, 8'd0);
                r_beat(vecs[i].exp, 4'(i), 2'b00, 1'b1, 1'b0);
            end
        end

        // Wrapping burst 15,0,1,2 with RREADY toggling; data held across each stall.
        ar_send(4'h9, BASE + 30'd120, 8'd3);
        for (int k = 0; k < 4; k++) r_beat(model[(15 + k) % NW], 4'h9, 2'b00, k == 3, 1'b1);

        // W beat and AR handshake on the same edge to word 5: read sees the old value.
        aw_send(4'h3, BASE + 30'd40, 8'd0);
        wvalid = 1'b1; wdata = 64'h1; wstrb = 8'hFF; wlast = 1'b1;
        arvalid = 1'b1; arid = 4'h4; araddr = BASE + 30'd40; arlen = 8'd0;
        check("same_edge_wready", 64'(wready), 64'd1);
        check("same_edge_arready", 64'(arready), 64'd1);
        @(negedge clock);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        model[5] = 64'h1;
        r_beat(64'h0, 4'h4, 2'b00, 1'b1, 1'b0);
        b_take(4'h3, 2'b00);
        ar_send(4'h5, BASE + 30'd40, 8'd0);
        r_beat(64'h1, 4'h5, 2'b00, 1'b1, 1'b0);

        // AW and AR accepted on the same edge to word 6.
        awvalid = 1'b1; awid = 4'h6; awaddr = BASE + 30'd48; awlen = 8'd0;
        arvalid = 1'b1; arid = 4'h7; araddr = BASE + 30'd48; arlen = 8'd0;
        check("dual_awready", 64'(awready), 64'd1);
        check("dual_arready", 64'(arready), 64'd1);
        @(negedge clock);
        awvalid = 1'b0; arvalid = 1'b0;
        w_beat(64'h2, 8'hFF, 1'b1, 6, 1'b1);
        r_beat(64'h0, 4'h7, 2'b00, 1'b1, 1'b0);
        b_take(4'h6, 2'b00);
        ar_send(4'h8, BASE + 30'd48, 8'd0);
        r_beat(64'h2, 4'h8, 2'b00, 1'b1, 1'b0);

        // Reset during beat 2 of an 8-beat write: burst abandoned, array cleared.
        aw_send(4'hA, BASE, 8'd7);
        w_beat(64'h1111, 8'hFF, 1'b0, 0, 1'b0);
        w_beat(64'h2222, 8'hFF, 1'b0, 1, 1'b0);
        wvalid = 1'b1; wdata = 64'h3333; wstrb = 8'hFF;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; wvalid = 1'b0;
        check("midrst_bvalid", 64'(bvalid), 64'd0);
        check("midrst_wready", 64'(wready), 64'd0);
        @(negedge clock);
        check("postrst_awready", 64'(awready), 64'd1);
        check("postrst_arready", 64'(arready), 64'd1);
        check("postrst_bvalid", 64'(bvalid), 64'd0);
        for (int i = 0; i < NW; i++) model[i] = 64'd0;
        r_held(4'hB, BASE, NW - 1, 0, 2'b00, 1'b0);
        check("postrst_no_b", 64'(bvalid), 64'd0);

        // Out-of-window accesses: aliased into the window, or rejected with SLVERR.
        aw_send(4'h1, BASE, 8'd1);
        w_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 0, 1'b1);
        w_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1, 1, 1'b1);
        b_take(4'h1, 2'b00);
`ifdef MMIO_RESP_ERR_EN
        r_held(4'hC, BASE + 30'd128, 1, 0, 2'b10, 1'b1);
        aw_send(4'hD, BASE + 30'd160, 8'd0);
        w_beat(64'h4444, 8'hFF, 1'b1, 4, 1'b0);
        b_take(4'hD, 2'b10);
`else
        r_held(4'hC, BASE + 30'd128, 1, 0, 2'b00, 1'b0);
        aw_send(4'hD, BASE + 30'd160, 8'd0);
        w_beat(64'h4444, 8'hFF, 1'b1, 4, 1'b1);
        b_take(4'hD, 2'b00);
`endif
        ar_send(4'hE, BASE + 30'd32, 8'd0);
        r_beat(model[4], 4'hE, 2'b00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
